mem_dump_reader: RTL

//  Reads the byte-wide, big-endian data memory back out as 32-bit words over a valid/ready stream.

---
 rtl/mem_dump_reader_if.sv | 52 +++++
 rtl/mem_dump_reader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_dump_reader_if.sv
// Dump reader bus bundle: request, byte memory
// read port and 32-bit word stream.
interface mem_dump_reader_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              word_valid;
  logic              word_ready;
  logic [31:0]       word_data;
  logic [ADDR_W-1:0] word_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start,
    input  base_addr,
    input  word_count,
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output word_valid,
    input  word_ready,
    output word_data,
    output word_addr,
    output busy,
    output done,
    output err
  );

  modport master (
    output start,
    output base_addr,
    output word_count,
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  word_valid,
    output word_ready,
    input  word_data,
    input  word_addr,
    input  busy,
    input  done,
    input  err
  );
endinterface

// File: rtl/mem_dump_reader.sv
// Reads big-endian byte memory back as a stream
// of 32-bit words with their byte addresses.
module mem_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst,
  mem_dump_reader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_OUT,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [1:0]        r_idx;
  logic [31:0]       r_data;
  logic              r_done;
  logic              r_err;

  logic w_accept;
  logic w_reject;
  logic w_rd_en;
  logic w_valid;
  logic w_busy;
  logic w_fin;
  logic w_hs;
  logic w_shift;
  logic w_misal;
  logic [ADDR_W-1:0] w_byte_off;

  assign w_misal = bus.base_addr[1:0] != 2'b00;
  assign w_byte_off = {{(ADDR_W-2){1'b0}}, r_idx};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and per-state strobes
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_rd_en  = 1'b0;
    w_valid  = 1'b0;
    w_busy   = 1'b0;
    w_fin    = 1'b0;
    w_hs     = 1'b0;
    w_shift  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_misal || bus.word_count == '0) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = S_RD;
          end
        end
      end
      S_RD: begin
        w_rd_en = 1'b1;
        w_busy  = 1'b1;
        w_shift = r_idx != 2'd0;
        if (r_idx == 2'd3) w_next = S_CAP;
      end
      S_CAP: begin
        w_busy  = 1'b1;
        w_shift = 1'b1;
        w_next  = S_OUT;
      end
      S_OUT: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        if (bus.word_ready) begin
          w_hs   = 1'b1;
          w_next = (r_rem == CNT_W'(1)) ? S_FIN : S_RD;
        end
      end
      S_FIN: begin
        w_fin  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address, count, byte index and word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_idx  <= 2'd0;
      r_data <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_reject;
      r_err  <= w_reject && w_misal;
      if (w_accept) begin
        r_addr <= bus.base_addr;
        r_rem  <= bus.word_count;
        r_idx  <= 2'd0;
      end
      if (w_rd_en) r_idx <= r_idx + 2'd1;
      if (w_shift) r_data <= {r_data[23:0], bus.mem_rdata};
      if (w_hs) begin
        r_addr <= r_addr + ADDR_W'(4);
        r_rem  <= r_rem - CNT_W'(1);
      end
    end
  end

  assign bus.mem_rd_en  = w_rd_en;
  assign bus.mem_addr   = w_rd_en ? r_addr + w_byte_off : '0;
  assign bus.word_valid = w_valid;
  assign bus.word_data  = w_valid ? r_data : '0;
  assign bus.word_addr  = w_valid ? r_addr : '0;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done | w_fin;
  assign bus.err        = r_err;
endmodule
